control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 74 +++++++
 rtl/instr_decoder.sv | 39 +++
 rtl/control_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the control sequencer:
//   - 5-bit opcode constants (IR[31:27])
//   - ALUop codes driven to the datapath ALU
//   - sequencer state encoding (T0..T7, HALT)
//   - instruction classes produced by instr_decoder
//   - ctrl_t: the packed bundle of every control strobe plus ALUop
//   - last_state(): the final execution step of each instruction class
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ADDI, CL_BR, CL_NOP, CL_HALT, CL_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       c_out;
    logic       ba_out;
    logic       r_out;
    logic       mar_in;
    logic       mdr_in;
    logic       ir_in;
    logic       pc_in;
    logic       y_in;
    logic       z_in;
    logic       r_in;
    logic       con_in;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic [3:0] alu_op;
  } ctrl_t;

  // Step on which an instruction completes; Stop is honoured only here.
  // nop, halt and an untrapped undefined opcode all finish at T2.
  function automatic state_e last_state(input instr_class_e c);
    case (c)
      CL_ALU, CL_ADDI, CL_LDI: last_state = S_T5;
      CL_BR:                   last_state = S_T6;
      CL_LD, CL_ST:            last_state = S_T7;
      default:                 last_state = S_T2;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational map from the opcode field to an instruction class and
// the ALU operation that class uses during execution.
// Ports:
//   i_opcode  [4:0]  IR[31:27]
//   o_class          instruction class (CL_ILLEGAL for undefined opcodes)
//   o_alu_op  [3:0]  ALU operation for the class's ALU step
// -----------------------------------------------------------------------------
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]   i_opcode,
  output instr_class_e o_class,
  output logic [3:0]   o_alu_op
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_class  = CL_ILLEGAL;
    o_alu_op = ALU_NONE;
    case (i_opcode)
      OP_LD:   begin o_class = CL_LD;   o_alu_op = ALU_ADD; end
      OP_LDI:  begin o_class = CL_LDI;  o_alu_op = ALU_ADD; end
      OP_ST:   begin o_class = CL_ST;   o_alu_op = ALU_ADD; end
      OP_ADD:  begin o_class = CL_ALU;  o_alu_op = ALU_ADD; end
      OP_SUB:  begin o_class = CL_ALU;  o_alu_op = ALU_SUB; end
      OP_AND:  begin o_class = CL_ALU;  o_alu_op = ALU_AND; end
      OP_OR:   begin o_class = CL_ALU;  o_alu_op = ALU_OR;  end
      OP_ADDI: begin o_class = CL_ADDI; o_alu_op = ALU_ADD; end
      OP_BR:   begin o_class = CL_BR;   o_alu_op = ALU_ADD; end
      OP_NOP:  o_class = CL_NOP;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired T-state control unit: fetch (T0..T2), per-class execute steps
// (T3..T7), and a HALT state left only through i_clear.
// Build option: define ILLEGAL_TRAP_EN to halt on undefined opcodes and raise
// o_illegal; otherwise undefined opcodes behave as nop and o_illegal is 0.
// Ports:
//   i_clock, i_clear (async, active high), i_ir[31:0], i_branch_met, i_stop
//   bus drives : o_pc_out o_zlow_out o_mdr_out o_c_out o_ba_out o_r_out
//   loads      : o_mar_in o_mdr_in o_ir_in o_pc_in o_y_in o_z_in o_r_in o_con_in
//   misc       : o_inc_pc o_read o_write o_gra o_grb o_grc o_alu_op[3:0]
//   status     : o_run (low only in HALT), o_illegal
// -----------------------------------------------------------------------------
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic [31:0] i_ir,
  input  logic        i_branch_met,
  input  logic        i_stop,
  output logic        o_pc_out,
  output logic        o_zlow_out,
  output logic        o_mdr_out,
  output logic        o_c_out,
  output logic        o_ba_out,
  output logic        o_r_out,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_ir_in,
  output logic        o_pc_in,
  output logic        o_y_in,
  output logic        o_z_in,
  output logic        o_r_in,
  output logic        o_con_in,
  output logic        o_inc_pc,
  output logic        o_read,
  output logic        o_write,
  output logic        o_gra,
  output logic        o_grb,
  output logic        o_grc,
  output logic [3:0]  o_alu_op,
  output logic        o_run,
  output logic        o_illegal
);

  state_e       r_state;
  state_e       w_next;
  instr_class_e w_class;
  logic [3:0]   w_alu;
  logic         w_trap;
  ctrl_t        w_ctrl;
  logic         w_unused_ir;

  // Register fields are routed to the register file elsewhere.
  assign w_unused_ir = ^i_ir[26:0];

  instr_decoder u_dec (
    .i_opcode (i_ir[31:27]),
    .o_class  (w_class),
    .o_alu_op (w_alu)
  );

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  assign w_trap = (w_class == CL_ILLEGAL);

  // Sticky until Clear so the fault stays visible after IR moves on.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear)                         r_illegal <= 1'b0;
    else if (r_state == S_T2 && w_trap)  r_illegal <= 1'b1;
  end
  assign o_illegal = r_illegal;
`else
  assign w_trap    = 1'b0;
  assign o_illegal = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) r_state <= S_T0;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_HALT: w_next = S_HALT;
      default: begin
        if (r_state == last_state(w_class)) begin
          if (w_class == CL_HALT || w_trap || i_stop) w_next = S_HALT;
          else                                         w_next = S_T0;
        end else begin
          w_next = state_e'(r_state + 4'd1);
        end
      end
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    // Clear forces T0 asynchronously, but T0 normally drives fetch strobes;
    // gating here keeps the bus quiet for as long as Clear is held.
    if (!i_clear) begin
      case (r_state)
        S_T0: begin
          w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
          w_ctrl.inc_pc = 1'b1; w_ctrl.z_in   = 1'b1;
        end
        S_T1: begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in  = 1'b1;
          w_ctrl.read     = 1'b1; w_ctrl.mdr_in = 1'b1;
        end
        S_T2: begin
          w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
        end
        S_T3: case (w_class)
          CL_ALU, CL_ADDI: begin
            w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1;
          end
          CL_LDI, CL_LD, CL_ST: begin
            w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
          end
          CL_BR: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.con_in = 1'b1;
          end
          default: ;
        endcase
        S_T4: case (w_class)
          CL_ALU: begin
            w_ctrl.grc = 1'b1; w_ctrl.r_out = 1'b1;
            w_ctrl.z_in = 1'b1; w_ctrl.alu_op = w_alu;
          end
          CL_ADDI, CL_LDI, CL_LD, CL_ST: begin
            w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu_op = w_alu;
          end
          CL_BR: begin
            w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
          end
          default: ;
        endcase
        S_T5: case (w_class)
          CL_ALU, CL_ADDI, CL_LDI: begin
            w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CL_LD, CL_ST: begin
            w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
          end
          CL_BR: begin
            w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu_op = w_alu;
          end
          default: ;
        endcase
        S_T6: case (w_class)
          CL_LD: begin
            w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
          end
          CL_ST: begin
            w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.mdr_in = 1'b1;
          end
          CL_BR: begin
            // CON flip-flop was loaded at T3, so its result is settled here.
            w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = i_branch_met;
          end
          default: ;
        endcase
        S_T7: case (w_class)
          CL_LD: begin
            w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1;
          end
          CL_ST: w_ctrl.write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  assign o_pc_out   = w_ctrl.pc_out;
  assign o_zlow_out = w_ctrl.zlow_out;
  assign o_mdr_out  = w_ctrl.mdr_out;
  assign o_c_out    = w_ctrl.c_out;
  assign o_ba_out   = w_ctrl.ba_out;
  assign o_r_out    = w_ctrl.r_out;
  assign o_mar_in   = w_ctrl.mar_in;
  assign o_mdr_in   = w_ctrl.mdr_in;
  assign o_ir_in    = w_ctrl.ir_in;
  assign o_pc_in    = w_ctrl.pc_in;
  assign o_y_in     = w_ctrl.y_in;
  assign o_z_in     = w_ctrl.z_in;
  assign o_r_in     = w_ctrl.r_in;
  assign o_con_in   = w_ctrl.con_in;
  assign o_inc_pc   = w_ctrl.inc_pc;
  assign o_read     = w_ctrl.read;
  assign o_write    = w_ctrl.write;
  assign o_gra      = w_ctrl.gra;
  assign o_grb      = w_ctrl.grb;
  assign o_grc      = w_ctrl.grc;
  assign o_alu_op   = w_ctrl.alu_op;
  assign o_run      = (r_state != S_HALT);

endmodule
